// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the character LCD sequencer.
// Optional power-on init sequence is enabled by defining LCD_CTRL_INIT_EN.
package lcd_pkg;

`ifdef LCD_CTRL_INIT_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_INIT_POWER,
    ST_INIT_SEQ
  } lcd_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_t;
`endif

  // Power-on command sequence: 8-bit bus/2 lines (x3), display on, clear, entry mode.
  localparam int INIT_LEN = 6;
  localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ_BYTES =
    {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

  // Commands that need the long execution wait.
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  // Bit positions inside lcd_ctrl.
  localparam int CTRL_RS_BIT = 0;
  localparam int CTRL_RW_BIT = 1;

  // True when a byte is a clear/home command and needs the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_controller_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy; full/empty derive
// from the occupancy register. A push while full is dropped.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_controller.sv
// lcd_controller: plays queued command/data bytes onto an 8-bit character LCD
// with programmable setup, enable pulse, hold and execution wait timing.
// Define LCD_CTRL_INIT_EN to add the power-on delay and init command sequence.
module lcd_controller #(
  parameter int DEPTH             = 8,
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 12,
  parameter int HOLD_CYCLES       = 2,
  parameter int CMD_WAIT_CYCLES   = 1000,
  parameter int CLEAR_WAIT_CYCLES = 40000,
  parameter int POWERUP_CYCLES    = 400000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rs,
  input  logic [7:0]               req_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               lcd_data,
  output logic [1:0]               lcd_ctrl,
  output logic                     lcd_enable
);

  import lcd_pkg::*;

  localparam int M1      = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int M2      = (M1 > HOLD_CYCLES) ? M1 : HOLD_CYCLES;
  localparam int M3      = (M2 > CMD_WAIT_CYCLES) ? M2 : CMD_WAIT_CYCLES;
  localparam int M4      = (M3 > CLEAR_WAIT_CYCLES) ? M3 : CLEAR_WAIT_CYCLES;
  localparam int MAX_CYC = (M4 > POWERUP_CYCLES) ? M4 : POWERUP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

`ifdef LCD_CTRL_INIT_EN
  localparam lcd_state_t RESET_STATE = ST_INIT_POWER;
  localparam logic [CNT_W-1:0] RESET_COUNT = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic RESET_BUSY = 1'b1;
  logic [2:0] init_idx;
`else
  localparam lcd_state_t RESET_STATE = ST_IDLE;
  localparam logic [CNT_W-1:0] RESET_COUNT = '0;
  localparam logic RESET_BUSY = 1'b0;
`endif

  lcd_state_t       state;
  logic [CNT_W-1:0] count;
  logic             cur_long;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [8:0]       head;

  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == ST_IDLE) && !empty;

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({req_rs, req_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Byte sequencer: one shared down-counter times every phase, pins are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET_STATE;
      count      <= RESET_COUNT;
      busy       <= RESET_BUSY;
      lcd_data   <= '0;
      lcd_ctrl   <= '0;
      lcd_enable <= 1'b0;
      cur_long   <= 1'b0;
`ifdef LCD_CTRL_INIT_EN
      init_idx   <= '0;
`endif
    end else begin
      busy <= (state != ST_IDLE) || !empty;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            lcd_data              <= head[7:0];
            lcd_ctrl[CTRL_RS_BIT] <= head[8];
            lcd_ctrl[CTRL_RW_BIT] <= 1'b0;
            cur_long              <= is_long_cmd(head[8], head[7:0]);
            count                 <= CNT_W'(SETUP_CYCLES - 1);
            state                 <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (count == '0) begin
            lcd_enable <= 1'b1;
            count      <= CNT_W'(PULSE_CYCLES - 1);
            state      <= ST_PULSE;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_PULSE: begin
          if (count == '0) begin
            lcd_enable <= 1'b0;
            count      <= CNT_W'(HOLD_CYCLES - 1);
            state      <= ST_HOLD;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_HOLD: begin
          if (count == '0) begin
            count <= cur_long ? CNT_W'(CLEAR_WAIT_CYCLES - 1) : CNT_W'(CMD_WAIT_CYCLES - 1);
            state <= ST_WAIT;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_WAIT: begin
          if (count == '0) begin
`ifdef LCD_CTRL_INIT_EN
            state <= (init_idx < 3'(INIT_LEN)) ? ST_INIT_SEQ : ST_IDLE;
`else
            state <= ST_IDLE;
`endif
          end else begin
            count <= count - 1'b1;
          end
        end
`ifdef LCD_CTRL_INIT_EN
        ST_INIT_POWER: begin
          if (count == '0) begin
            state <= ST_INIT_SEQ;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_INIT_SEQ: begin
          lcd_data              <= INIT_SEQ_BYTES[init_idx];
          lcd_ctrl[CTRL_RS_BIT] <= 1'b0;
          lcd_ctrl[CTRL_RW_BIT] <= 1'b0;
          cur_long              <= is_long_cmd(1'b0, INIT_SEQ_BYTES[init_idx]);
          count                 <= CNT_W'(SETUP_CYCLES - 1);
          init_idx              <= init_idx + 1'b1;
          state                 <= ST_SETUP;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_controller.sv
// tb_lcd_controller: directed and randomized checks of the LCD sequencer
// against a transaction-level timing model (push time -> pop/enable times).
module tb_lcd_controller;

  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int P     = 3;
  localparam int H     = 1;
  localparam int CMDW  = 5;
  localparam int CLRW  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;
  logic       busy;
  logic [2:0] level;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;
  logic       lcd_enable;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Monitor capture of enable edges.
  int         rise_cyc[$];
  logic [9:0] rise_val[$];
  int         fall_cyc[$];
  logic       prev_en = 1'b0;

  // Model of accepted requests.
  int         m_push[$];
  int         m_pop[$];
  logic [9:0] m_val[$];
  int         last_pop = -1000;
  int         last_dur = 0;

  lcd_controller #(
    .DEPTH             (DEPTH),
    .SETUP_CYCLES      (S),
    .PULSE_CYCLES      (P),
    .HOLD_CYCLES       (H),
    .CMD_WAIT_CYCLES   (CMDW),
    .CLEAR_WAIT_CYCLES (CLRW),
    .POWERUP_CYCLES    (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs     (req_rs),
    .req_data   (req_data),
    .busy       (busy),
    .level      (level),
    .lcd_data   (lcd_data),
    .lcd_ctrl   (lcd_ctrl),
    .lcd_enable (lcd_enable)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record enable rise/fall edges and the pin values at each rise.
  always @(negedge clk) begin
    if (lcd_enable && !prev_en) begin
      rise_cyc.push_back(cyc);
      rise_val.push_back({lcd_ctrl, lcd_data});
    end
    if (!lcd_enable && prev_en) fall_cyc.push_back(cyc);
    prev_en <= lcd_enable;
  end

  // Runaway guard.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int waitOf(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CLRW : CMDW;
  endfunction

  function automatic int modelLevel(input int k);
    int n = 0;
    foreach (m_push[i]) if (m_push[i] <= k && m_pop[i] > k) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one request for one edge and update the model with its fate.
  task automatic applyStimulus(input logic rs, input logic [7:0] d);
    int t;
    int p;
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    @(posedge clk);
    #1;
    t = cyc;
    if (modelLevel(t - 1) < DEPTH) begin
      p = (t + 1 > last_pop + last_dur + 1) ? t + 1 : last_pop + last_dur + 1;
      m_push.push_back(t);
      m_pop.push_back(p);
      m_val.push_back({1'b0, rs, d});
      last_pop = p;
      last_dur = S + P + H + waitOf(rs, d);
    end
  endtask

  task automatic toEdge(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain();
    toEdge(last_pop + last_dur + 3);
  endtask

  task automatic clearQueues();
    rise_cyc.delete();
    rise_val.delete();
    fall_cyc.delete();
    m_push.delete();
    m_pop.delete();
    m_val.delete();
  endtask

  // Compare every recorded enable pulse with the model's prediction.
  task automatic checkTransfers(input string tag);
    checkOutput({tag, "_count"}, rise_cyc.size(), m_pop.size());
    foreach (m_pop[i]) begin
      checkOutput({tag, "_rise_cyc"}, (i < rise_cyc.size()) ? rise_cyc[i] : -1, m_pop[i] + S);
      checkOutput({tag, "_rise_val"}, (i < rise_val.size()) ? {22'd0, rise_val[i]} : 32'hFFFF_FFFF,
                  {22'd0, m_val[i]});
      checkOutput({tag, "_fall_cyc"}, (i < fall_cyc.size()) ? fall_cyc[i] : -1, m_pop[i] + S + P);
    end
    clearQueues();
  endtask

  // Single data byte with explicit pin timing.
  task automatic singleByte(input string tag);
    int n;
    applyStimulus(1'b1, 8'h41);
    req_valid = 1'b0;
    n = cyc;
    toEdge(n + 1);
    checkOutput({tag, "_data"}, lcd_data, 8'h41);
    checkOutput({tag, "_ctrl"}, lcd_ctrl, 2'b01);
    checkOutput({tag, "_level"}, level, modelLevel(cyc));
    toEdge(n + 2);
    checkOutput({tag, "_en_pre"}, lcd_enable, 1'b0);
    toEdge(n + 3);
    checkOutput({tag, "_en_rise"}, lcd_enable, 1'b1);
    toEdge(n + 5);
    checkOutput({tag, "_en_last"}, lcd_enable, 1'b1);
    toEdge(n + 6);
    checkOutput({tag, "_en_fall"}, lcd_enable, 1'b0);
    toEdge(n + 12);
    checkOutput({tag, "_busy_hi"}, busy, 1'b1);
    toEdge(n + 13);
    checkOutput({tag, "_busy_lo"}, busy, 1'b0);
    checkOutput({tag, "_data_kept"}, lcd_data, 8'h41);
    drain();
    checkTransfers(tag);
  endtask

  initial begin
    int gap;
    int n;
    int cnt;
    logic       rs;
    logic [7:0] d;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_data", lcd_data, 8'h00);
    checkOutput("rst_ctrl", lcd_ctrl, 2'b00);
    checkOutput("rst_en", lcd_enable, 1'b0);
    checkOutput("rst_level", level, 3'd0);
    checkOutput("rst_ready", req_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);

    $display("[TB] single byte");
    singleByte("single");

    $display("[TB] back-to-back bytes");
    applyStimulus(1'b1, 8'h41);
    applyStimulus(1'b1, 8'h42);
    applyStimulus(1'b1, 8'h43);
    req_valid = 1'b0;
    drain();
    checkOutput("b2b_gap01", (rise_cyc.size() >= 2) ? rise_cyc[1] - rise_cyc[0] : -1, 12);
    checkOutput("b2b_gap12", (rise_cyc.size() >= 3) ? rise_cyc[2] - rise_cyc[1] : -1, 12);
    checkTransfers("b2b");

    $display("[TB] clear wait gap");
    applyStimulus(1'b0, 8'h01);
    applyStimulus(1'b1, 8'h20);
    req_valid = 1'b0;
    drain();
    checkOutput("clr_gap", (fall_cyc.size() >= 2) ? fall_cyc[1] - fall_cyc[0] : -1, 27);
    checkTransfers("clr");
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h20);
    req_valid = 1'b0;
    drain();
    checkOutput("data01_gap", (fall_cyc.size() >= 2) ? fall_cyc[1] - fall_cyc[0] : -1, 12);
    checkTransfers("data01");

    $display("[TB] overflow");
    applyStimulus(1'b0, 8'h01);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'hA0 + 8'(i));
    req_valid = 1'b0;
    checkOutput("ovf_level", level, 3'd4);
    checkOutput("ovf_ready", req_ready, 1'b0);
    checkOutput("ovf_level_model", level, modelLevel(cyc));
    drain();
    checkTransfers("ovf");

    $display("[TB] randomized rounds");
    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(1, 6);
      for (int k = 0; k < cnt; k++) begin
        rs = 1'($urandom_range(0, 1));
        d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
        applyStimulus(rs, d);
        checkOutput("rnd_level", level, modelLevel(cyc));
        checkOutput("rnd_ready", req_ready, (modelLevel(cyc) < DEPTH) ? 1'b1 : 1'b0);
        if ($urandom_range(0, 1) == 1) begin
          req_valid = 1'b0;
          gap = $urandom_range(1, 3);
          repeat (gap) @(posedge clk);
          #1;
        end
      end
      req_valid = 1'b0;
      drain();
      checkTransfers("rnd");
    end

    $display("[TB] reset mid-pulse");
    applyStimulus(1'b1, 8'h55);
    n = cyc;
    applyStimulus(1'b1, 8'h56);
    applyStimulus(1'b0, 8'h0C);
    req_valid = 1'b0;
    toEdge(n + 4);
    checkOutput("mid_en", lcd_enable, 1'b1);
    checkOutput("mid_level", level, modelLevel(cyc));
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_en", lcd_enable, 1'b0);
    checkOutput("arst_data", lcd_data, 8'h00);
    checkOutput("arst_ctrl", lcd_ctrl, 2'b00);
    checkOutput("arst_level", level, 3'd0);
    checkOutput("arst_ready", req_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    clearQueues();
    last_pop = -1000;
    last_dur = 0;
    @(negedge clk);
    singleByte("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
